autosym_projector_eval: RTL and testbench
=========================================

// Module: autosym_projector_eval
// PURPOSE
// - Driving side of a restricted (reduced-space) Boolean function block: accepts a full-space input vector x,
//   projects it onto the reduced space via a programmable GF(2) matrix (red_x[i] = ^(A[i] & x)),
//   presents red_x to the external combinational restriction, samples its single output and returns it as f(x).
// - Sits between the full-width benchmark stimulus and a synthesised restriction netlist (NI inputs, 1 output).
// PARAMETERS
// - N_FULL  10  width of full-space input x
// - N_RED   9   width of reduced-space vector red_x (= restriction input count)
// - ROW_W   4   width of matrix row index, ceil(log2(N_RED))
// PORTS
// - clk        in   1       single clock, rising edge
// - rst        in   1       synchronous reset, active-high
// - cfg_we     in   1       matrix row write strobe
// - cfg_row    in   ROW_W   row index to write
// - cfg_data   in   N_FULL  row contents A[cfg_row]
// - cfg_err    out  1       1-cycle pulse: write rejected (busy or cfg_row >= N_RED)
// - in_valid   in   1       x offered
// - in_ready   out  1       block can accept x
// - in_x       in   N_FULL  full-space input vector
// - red_x      out  N_RED   registered reduced vector to restriction netlist
// - red_y      in   1       restriction output (combinational from red_x)
// - out_valid  out  1       result available
// - out_ready  in   1       consumer accepts result
// - out_y      out  1       f(x)
// BEHAVIOUR
// - Reset: A[i] = one-hot bit i (identity on low N_RED bits); red_x=0, out_valid=0, out_y=0, cfg_err=0,
//   in_ready=1, FSM=IDLE. Reset mid-operation aborts; in-flight result discarded, matrix reset to identity.
// - FSM: IDLE -> PROJ -> SETTLE -> DONE -> IDLE.
//   IDLE: in_ready=1; on in_valid&in_ready latch in_x to x_q, clear red_x, row counter r=0, go PROJ.
//   PROJ: one row per cycle: red_x[r] <= ^(A[r] & x_q); r++; after r=N_RED-1 go SETTLE (N_RED cycles).
//   SETTLE: one cycle for red_y to settle through netlist; at end sample out_y <= red_y, go DONE.
//   DONE: out_valid=1, out_y stable; on out_ready go IDLE (out_valid drops next cycle).
// - Latency: handshake at cycle 0 -> out_valid at cycle N_RED+2 (11 with defaults). No overlap: in_ready=0
//   from PROJ through DONE; throughput one vector per N_RED+3 cycles minimum.
// - red_x holds its last value in IDLE/DONE (netlist input never glitches between operations).
// - Config: write accepted only in IDLE and cfg_row < N_RED; else A unchanged and cfg_err pulses next cycle.
//   cfg_we and in_valid in same IDLE cycle: write takes effect first; the new vector uses the new row.
// - out_ready while out_valid=0 ignored. in_valid while in_ready=0 ignored (x not latched).
// - All-zero row: red_x[i]=0. Parity is plain XOR reduction, no carry/width extension.
// STRUCTURE
// - Shared package autosym_pkg: N_FULL/N_RED defaults, FSM state enum {IDLE,PROJ,SETTLE,DONE},
//   function parity_row(row,x) returning ^(row & x).
// - One sub-module: autosym_matrix_regs (N_RED x N_FULL row store, write port, identity reset,
//   read port by index). FSM, counter and datapath stay in top.
// TESTING (bench stub restriction: red_y = ^red_x)
// - Reset, no config, in_x=10'h3FF -> red_x=9'h1FF, out_y=1 (parity of 9 ones), out_valid at cycle 11.
// - Write A[0]=10'h200, rest zero rows; in_x=10'h200 -> red_x=9'h001, out_y=1; in_x=10'h1FF -> out_y=0.
// - cfg_we while FSM in PROJ, and cfg_row=9 in IDLE -> cfg_err pulse each time, A unchanged, result unaffected.
// - Hold out_ready=0 for 5 cycles after out_valid -> out_y/red_x stable, in_ready=0; next vector accepted only after out_ready.
// - Assert rst during PROJ (cycle 4) -> next cycle out_valid=0, in_ready=1, red_x=0, A = identity.
// - Same-cycle cfg_we(A[1]=10'h003) + in_valid(in_x=10'h001): red_x[1]=1 using new row.

Source files
------------

// File: rtl/autosym_pkg.sv
// Shared definitions for the reduced-space projector: default widths, FSM states
// and the GF(2) row-parity helper.
package autosym_pkg;

  localparam int DEF_N_FULL = 10;
  localparam int DEF_N_RED  = 9;
  localparam int DEF_ROW_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    PROJ,
    SETTLE,
    DONE
  } state_t;

  // One output bit of the projection: inner product of a matrix row with x over GF(2).
  function automatic logic parity_row(input logic [DEF_N_FULL-1:0] row,
                                      input logic [DEF_N_FULL-1:0] x);
    return ^(row & x);
  endfunction

endpackage

// File: rtl/autosym_matrix_regs.sv
// Row store for the N_RED x N_FULL projection matrix; resets to the identity on
// the low N_RED input bits. Write qualification is done by the caller.
module autosym_matrix_regs #(
  parameter int N_FULL = 10,
  parameter int N_RED  = 9,
  parameter int ROW_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [N_FULL-1:0] wr_data,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [N_FULL-1:0] rd_data
);

  logic [N_FULL-1:0] rows [N_RED];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_RED; i++) begin
        rows[i] <= N_FULL'(1) << i;
      end
    end else if (we) begin
      rows[wr_row] <= wr_data;
    end
  end

  // Out-of-range indices read as an all-zero row rather than an undefined entry.
  assign rd_data = (rd_row < ROW_W'(N_RED)) ? rows[rd_row] : '0;

endmodule

// File: rtl/autosym_projector_eval.sv
// Drives a reduced-space restriction netlist: projects x one row per cycle into red_x,
// waits one settle cycle, then samples the netlist output as f(x).
module autosym_projector_eval
  import autosym_pkg::*;
#(
  parameter int N_FULL = DEF_N_FULL,
  parameter int N_RED  = DEF_N_RED,
  parameter int ROW_W  = DEF_ROW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ROW_W-1:0]  cfg_row,
  input  logic [N_FULL-1:0] cfg_data,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_FULL-1:0] in_x,
  output logic [N_RED-1:0]  red_x,
  input  logic              red_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_y
);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  r_q;
  logic [N_FULL-1:0] x_q;
  logic [N_FULL-1:0] row_data;
  logic              cfg_ok;
  logic              accept;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready && in_valid;
  assign cfg_ok    = cfg_we && (state_q == IDLE) && (cfg_row < ROW_W'(N_RED));

  // Writing in the same IDLE cycle as an accept is safe: rows are read only from PROJ on.
  autosym_matrix_regs #(
    .N_FULL (N_FULL),
    .N_RED  (N_RED),
    .ROW_W  (ROW_W)
  ) u_matrix (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_ok),
    .wr_row  (cfg_row),
    .wr_data (cfg_data),
    .rd_row  (r_q),
    .rd_data (row_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = PROJ;
      PROJ:    if (r_q == ROW_W'(N_RED - 1)) state_d = SETTLE;
      SETTLE:  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // red_x only changes during PROJ or on a new accept, so the netlist input is quiet otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      r_q     <= '0;
      red_x   <= '0;
      out_y   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q   <= in_x;
            red_x <= '0;
            r_q   <= '0;
          end
        end
        PROJ: begin
          red_x[r_q] <= parity_row(row_data, x_q);
          r_q        <= r_q + 1'b1;
        end
        SETTLE: out_y <= red_y;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_autosym_projector_eval.sv
// Self-checking bench for autosym_projector_eval with a parity stub standing in
// for the restriction netlist and a whole-vector matrix model.
module tb_autosym_projector_eval;

  localparam int NF = 10;
  localparam int NR = 9;
  localparam int RW = 4;
  localparam int LAT = NR + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [RW-1:0] cfg_row = '0;
  logic [NF-1:0] cfg_data = '0;
  logic          cfg_err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [NF-1:0] in_x = '0;
  logic [NR-1:0] red_x;
  logic          red_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_y;

  int vectors = 0;
  int miscompares = 0;

  logic [NF-1:0] mdl_a [NR];

  assign red_y = ^red_x;

  always #5 clk = ~clk;

  autosym_projector_eval dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_row   (cfg_row),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .red_x     (red_x),
    .red_y     (red_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_identity();
    for (int i = 0; i < NR; i++) mdl_a[i] = NF'(1) << i;
  endfunction

  function automatic logic [NR-1:0] model_proj(input logic [NF-1:0] x);
    logic [NR-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i] = ^(mdl_a[i] & x);
    return v;
  endfunction

  task automatic write_row(input logic [RW-1:0] row, input logic [NF-1:0] data);
    cfg_we   = 1'b1;
    cfg_row  = row;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Handshake x, then count cycles until out_valid; lat = -1 if it never arrives.
  task automatic send_vector(input logic [NF-1:0] x, output int lat);
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_identity();
    vectors++;
    if ({in_ready, out_valid, out_y, cfg_err} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got rdy/vld/y/err=%b expected 1000", {in_ready, out_valid, out_y, cfg_err});
    end
    vectors++;
    if (red_x !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_red_x: got %h expected 000", red_x);
    end
  endtask

  task automatic test_identity();
    int lat;
    logic [NF-1:0] x;
    send_vector(10'h3FF, lat);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("[TB] FAIL id_latency: got %0d expected %0d", lat, LAT);
    end
    vectors++;
    if (red_x !== 9'h1FF || out_y !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL id_all_ones: got red_x=%h y=%b expected 1ff 1", red_x, out_y);
    end
    release_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL id_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
    for (int k = 0; k < 4; k++) begin
      x = NF'($urandom);
      send_vector(x, lat);
      vectors++;
      if (lat !== LAT || red_x !== model_proj(x) || out_y !== ^model_proj(x)) begin
        miscompares++;
        $display("[TB] FAIL id_random x=%h: got lat=%0d red_x=%h y=%b expected %0d %h %b",
                 x, lat, red_x, out_y, LAT, model_proj(x), ^model_proj(x));
      end
      release_result();
    end
  endtask

  task automatic test_single_row();
    int lat;
    write_row(4'd0, 10'h200);
    mdl_a[0] = 10'h200;
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL row_write_err: got %b expected 0", cfg_err);
    end
    for (int i = 1; i < NR; i++) begin
      write_row(RW'(i), '0);
      mdl_a[i] = '0;
    end
    send_vector(10'h200, lat);
    vectors++;
    if (lat !== LAT || red_x !== 9'h001 || out_y !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL row_x200: got lat=%0d red_x=%h y=%b expected %0d 001 1", lat, red_x, out_y, LAT);
    end
    release_result();
    send_vector(10'h1FF, lat);
    vectors++;
    if (lat !== LAT || red_x !== 9'h000 || out_y !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL row_x1ff: got lat=%0d red_x=%h y=%b expected %0d 000 0", lat, red_x, out_y, LAT);
    end
    release_result();
  endtask

  task automatic test_cfg_err();
    int lat;
    logic [NF-1:0] x;
    int row;
    for (int i = 0; i < NR; i++) begin
      mdl_a[i] = NF'($urandom);
      write_row(RW'(i), mdl_a[i]);
    end
    x = NF'($urandom);
    in_valid = 1'b1;
    in_x = x;
    tick();
    in_valid = 1'b0;
    tick();
    row = $urandom_range(0, NR - 1);
    write_row(RW'(row), ~mdl_a[row]);
    vectors++;
    if (cfg_err !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_busy: got err=%b rdy=%b expected 1 0", cfg_err, in_ready);
    end
    tick();
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_pulse: got %b expected 0", cfg_err);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++;
    if (out_valid !== 1'b1 || red_x !== model_proj(x) || out_y !== ^model_proj(x)) begin
      miscompares++;
      $display("[TB] FAIL err_busy_result x=%h: got vld=%b red_x=%h y=%b expected 1 %h %b",
               x, out_valid, red_x, out_y, model_proj(x), ^model_proj(x));
    end
    release_result();
    write_row(4'd9, NF'($urandom));
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_row9: got %b expected 1", cfg_err);
    end
    write_row(4'd15, NF'($urandom));
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_row15: got %b expected 1", cfg_err);
    end
    x = NF'($urandom);
    send_vector(x, lat);
    vectors++;
    if (lat !== LAT || red_x !== model_proj(x) || out_y !== ^model_proj(x)) begin
      miscompares++;
      $display("[TB] FAIL err_after x=%h: got lat=%0d red_x=%h y=%b expected %0d %h %b",
               x, lat, red_x, out_y, LAT, model_proj(x), ^model_proj(x));
    end
    release_result();
  endtask

  task automatic test_hold();
    int lat;
    logic [NF-1:0] x;
    logic [NR-1:0] exp_r;
    x = NF'($urandom);
    exp_r = model_proj(x);
    send_vector(x, lat);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("[TB] FAIL hold_latency: got %0d expected %0d", lat, LAT);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_x = ~x;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || red_x !== exp_r || out_y !== ^exp_r) begin
        miscompares++;
        $display("[TB] FAIL hold_cycle%0d: got vld=%b rdy=%b red_x=%h y=%b expected 1 0 %h %b",
                 c, out_valid, in_ready, red_x, out_y, exp_r, ^exp_r);
      end
    end
    in_valid = 1'b0;
    release_result();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || red_x !== exp_r) begin
      miscompares++;
      $display("[TB] FAIL hold_release: got vld=%b rdy=%b red_x=%h expected 0 1 %h", out_valid, in_ready, red_x, exp_r);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [NF-1:0] x;
    write_row(4'd0, 10'h3FF);
    in_valid = 1'b1;
    in_x = NF'($urandom);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_identity();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || red_x !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_state: got vld=%b rdy=%b red_x=%h expected 0 1 000", out_valid, in_ready, red_x);
    end
    send_vector(10'h3FF, lat);
    vectors++;
    if (lat !== LAT || red_x !== 9'h1FF || out_y !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midrst_identity: got lat=%0d red_x=%h y=%b expected %0d 1ff 1", lat, red_x, out_y, LAT);
    end
    release_result();
    x = NF'($urandom);
    send_vector(x, lat);
    vectors++;
    if (lat !== LAT || red_x !== model_proj(x) || out_y !== ^model_proj(x)) begin
      miscompares++;
      $display("[TB] FAIL midrst_random x=%h: got red_x=%h y=%b expected %h %b", x, red_x, out_y, model_proj(x), ^model_proj(x));
    end
    release_result();
  endtask

  task automatic test_same_cycle();
    int lat;
    cfg_we = 1'b1;
    cfg_row = 4'd1;
    cfg_data = 10'h003;
    in_valid = 1'b1;
    in_x = 10'h001;
    mdl_a[1] = 10'h003;
    send_vector(10'h001, lat);
    cfg_we = 1'b0;
    vectors++;
    if (lat !== LAT || red_x[1] !== 1'b1 || red_x !== model_proj(10'h001) || out_y !== ^model_proj(10'h001)) begin
      miscompares++;
      $display("[TB] FAIL same_cycle: got lat=%0d red_x=%h y=%b expected %0d %h %b",
               lat, red_x, out_y, LAT, model_proj(10'h001), ^model_proj(10'h001));
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    int row;
    logic [NF-1:0] x;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        row = $urandom_range(0, NR - 1);
        mdl_a[row] = NF'($urandom);
        write_row(RW'(row), mdl_a[row]);
      end
      x = NF'($urandom);
      send_vector(x, lat);
      vectors++;
      if (lat !== LAT || red_x !== model_proj(x) || out_y !== ^model_proj(x)) begin
        miscompares++;
        $display("[TB] FAIL b2b_%0d x=%h: got lat=%0d red_x=%h y=%b expected %0d %h %b",
                 k, x, lat, red_x, out_y, LAT, model_proj(x), ^model_proj(x));
      end
      tick();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready_%0d: got rdy=%b vld=%b expected 1 0", k, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_single_row();
    test_cfg_err();
    test_hold();
    test_reset_mid();
    test_same_cycle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

endmodule
